// File: rtl/adc_avg_filter.sv
// Windowed averager for SAR ADC codes: emits avg/min/max once per 2^LOG2_AVG samples, plus a stall flag.
// Optional round-half-up of the average is enabled by defining ADC_AVG_ROUND_EN.
//
// state | meaning
// ACCUM | accepting samples into the running window
// EMIT  | one cycle; outputs just loaded, avg_valid high, a concurrent sample still accumulates

module adc_avg_filter #(
    parameter int WIDTH          = 8,
    parameter int LOG2_AVG       = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    adc_code,
    input  logic                adc_ready,
    input  logic                clear,
    output logic [WIDTH-1:0]    avg_code,
    output logic [WIDTH-1:0]    min_code,
    output logic [WIDTH-1:0]    max_code,
    output logic                avg_valid,
    output logic [LOG2_AVG:0]   sample_cnt,
    output logic                stale
);

    localparam int ACC_W  = WIDTH + LOG2_AVG;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LOG2_AVG:0] LAST_CNT = (LOG2_AVG + 1)'((1 << LOG2_AVG) - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t            state, state_nxt;
    logic              load;
    logic              accept;
    logic              close;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  acc_rnd;
    logic [WIDTH-1:0]  run_min, run_max;
    logic [WIDTH-1:0]  min_next, max_next;
    logic [WIDTH-1:0]  avg_next;
    logic [IDLE_W-1:0] idle_cnt;

    assign accept   = adc_ready & ~clear;
    assign close    = accept && (sample_cnt == LAST_CNT);
    assign acc_sum  = acc + ACC_W'(adc_code);
    assign min_next = (adc_code < run_min) ? adc_code : run_min;
    assign max_next = (adc_code > run_max) ? adc_code : run_max;

`ifdef ADC_AVG_ROUND_EN
    generate
        if (LOG2_AVG == 0) begin : g_rnd_none
            assign acc_rnd = acc_sum;
        end else begin : g_rnd_half
            // Cannot overflow: a full window sums to at most (2^WIDTH-1)*2^LOG2_AVG.
            assign acc_rnd = acc_sum + ACC_W'(1 << (LOG2_AVG - 1));
        end
    endgenerate
`else
    assign acc_rnd = acc_sum;
`endif

    assign avg_next = WIDTH'(acc_rnd >> LOG2_AVG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // A close in EMIT is only possible with a one-sample window; it must not be dropped.
    always_comb begin
        state_nxt = ACCUM;
        load      = 1'b0;
        if (close) begin
            state_nxt = EMIT;
            load      = 1'b1;
        end
    end

    assign avg_valid = (state == EMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            sample_cnt <= '0;
            run_min    <= '1;
            run_max    <= '0;
            avg_code   <= '0;
            min_code   <= '0;
            max_code   <= '0;
        end else begin
            if (load) begin
                avg_code <= avg_next;
                min_code <= min_next;
                max_code <= max_next;
            end
            if (clear || close) begin
                acc        <= '0;
                sample_cnt <= '0;
                run_min    <= '1;
                run_max    <= '0;
            end else if (accept) begin
                acc        <= acc_sum;
                sample_cnt <= sample_cnt + 1'b1;
                run_min    <= min_next;
                run_max    <= max_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (adc_ready) begin
            idle_cnt <= '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign stale = (idle_cnt == IDLE_MAX);

endmodule
